// File: rtl/queue_arbiter.sv
// Two-requester round-robin enqueue arbiter in front of an 8x4 external
// register file, with a registered dequeue port and an 8-cycle clear sequence.
module queue_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] din0,
    input  logic [3:0] din1,
    output logic       ack0,
    output logic       ack1,
    input  logic       deq,
    output logic [3:0] dout,
    output logic       dvalid,
    input  logic       flush,
    output logic       busy,
    output logic       full,
    output logic       emp,
    output logic [3:0] count,
    output logic [7:0] valid,
    output logic [2:0] rp,
    output logic [2:0] wp,
    output logic [2:0] ra,
    input  logic [3:0] rd,
    output logic       we,
    output logic [2:0] wa,
    output logic [3:0] wd
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t     state, state_nx;
    logic [2:0] k;
    logic       prio;
    logic       gnt0, gnt1, grant, do_deq;

    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        do_deq   = 1'b0;
        we       = 1'b0;
        wa       = wp;
        wd       = din0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    // prio names the requester that wins a tie
                    if (count < 4'd8) begin
                        if (req0 && (!req1 || !prio))
                            gnt0 = 1'b1;
                        else if (req1)
                            gnt1 = 1'b1;
                    end
                    do_deq = deq && (count != 4'd0);
                    we     = gnt0 | gnt1;
                    wd     = gnt1 ? din1 : din0;
                    if (flush)
                        state_nx = FLUSH;
                end
                FLUSH: begin
                    we = 1'b1;
                    wa = k;
                    wd = 4'd0;
                    if (k == 3'd7)
                        state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign ack0  = gnt0;
    assign ack1  = gnt1;
    assign grant = gnt0 | gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= 3'd0;
            prio   <= 1'b0;
            rp     <= 3'd0;
            wp     <= 3'd0;
            count  <= 4'd0;
            valid  <= 8'd0;
            dout   <= 4'd0;
            dvalid <= 1'b0;
        end else begin
            state  <= state_nx;
            dvalid <= do_deq;
            if (do_deq) begin
                dout      <= rd;
                rp        <= rp + 3'd1;
                valid[rp] <= 1'b0;
            end
            if (grant) begin
                wp        <= wp + 3'd1;
                valid[wp] <= 1'b1;
                prio      <= gnt0;
            end
            if (grant && !do_deq)
                count <= count + 4'd1;
            else if (do_deq && !grant)
                count <= count - 4'd1;
            if (state == IDLE && flush)
                k <= 3'd0;
            if (state == FLUSH) begin
                k <= k + 3'd1;
                // last clear cycle empties the queue bookkeeping
                if (k == 3'd7) begin
                    rp    <= 3'd0;
                    wp    <= 3'd0;
                    count <= 4'd0;
                    valid <= 8'd0;
                end
            end
        end
    end

    assign busy = (state == FLUSH);
    assign full = (count == 4'd8);
    assign emp  = (count == 4'd0);
    assign ra   = rp;

endmodule

// File: tb/tb_queue_arbiter.sv
// Randomized scoreboard bench for queue_arbiter with a FIFO-level reference
// model and a behavioural register file on the RF port.
module tb_queue_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, deq = 1'b0, flush = 1'b0;
    logic [3:0] din0 = 4'd0, din1 = 4'd0;
    logic [3:0] rd, dout, count, wd;
    logic       ack0, ack1, dvalid, busy, full, emp, we;
    logic [7:0] valid;
    logic [2:0] rp, wp, ra, wa;
    logic [3:0] rf [8];

    always #5 clk = ~clk;

    queue_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .din0(din0), .din1(din1),
        .ack0(ack0), .ack1(ack1),
        .deq(deq), .dout(dout), .dvalid(dvalid),
        .flush(flush), .busy(busy),
        .full(full), .emp(emp), .count(count), .valid(valid),
        .rp(rp), .wp(wp), .ra(ra), .rd(rd),
        .we(we), .wa(wa), .wd(wd)
    );

    always @(posedge clk) if (we === 1'b1) rf[wa] <= wd;
    assign rd = rf[ra];

    typedef struct { int data; int due; } exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int errs = 0;
    int cyc = 0;

    int m_q[$];
    int m_rp, m_wp, m_k, m_prio, m_dout, m_g;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_rp = 0; m_wp = 0; m_k = -1; m_prio = 0; m_dout = 0; m_g = -1;
    endtask

    // Monitor: consumes expected dequeues whenever dvalid shows up
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("dvalid_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("deq_data", dout, e.data);
                    chk("deq_cycle", cyc, e.due);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                chk("dvalid_missing", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic r0, input logic [3:0] d0,
                        input logic r1, input logic [3:0] d1,
                        input logic dq, input logic fl, input logic rs);
        int g;
        logic dok;
        logic [7:0] ev;
        @(negedge clk);
        rst = rs; req0 = r0; din0 = d0; req1 = r1; din1 = d1;
        deq = dq; flush = fl;
        #1;
        ev = '0;
        for (int i = 0; i < m_q.size(); i++) ev[(m_rp + i) % 8] = 1'b1;
        chk("count", count, m_q.size());
        chk("full", full, m_q.size() == 8);
        chk("emp", emp, m_q.size() == 0);
        chk("busy", busy, m_k >= 0);
        chk("valid", valid, ev);
        chk("rp", rp, m_rp);
        chk("wp", wp, m_wp);
        chk("ra", ra, m_rp);
        chk("dout_hold", dout, m_dout);
        g = -1;
        dok = 1'b0;
        if (!rs && m_k < 0) begin
            if (m_q.size() < 8) begin
                if (r0 && r1) g = m_prio;
                else if (r0) g = 0;
                else if (r1) g = 1;
            end
            dok = dq && (m_q.size() > 0);
        end
        chk("ack0", ack0, g == 0);
        chk("ack1", ack1, g == 1);
        chk("we", we, !rs && (g >= 0 || m_k >= 0));
        if (!rs && m_k >= 0) begin
            chk("wa_flush", wa, m_k);
            chk("wd_flush", wd, 0);
        end else if (g >= 0) begin
            chk("wa", wa, m_wp);
            chk("wd", wd, (g == 0) ? d0 : d1);
        end
        m_g = g;
        @(posedge clk);
        cyc++;
        if (rs) begin
            m_reset();
        end else if (m_k >= 0) begin
            m_k++;
            if (m_k == 8) begin
                m_k = -1;
                m_q.delete();
                m_rp = 0;
                m_wp = 0;
            end
        end else begin
            if (dok) begin
                m_dout = m_q.pop_front();
                exp_q.push_back('{m_dout, cyc});
                m_rp = (m_rp + 1) % 8;
            end
            if (g >= 0) begin
                m_q.push_back((g == 0) ? int'(d0) : int'(d1));
                m_wp = (m_wp + 1) % 8;
                m_prio = 1 - g;
            end
            if (fl) m_k = 0;
        end
        m_g = g;
    endtask

    task automatic do_rst();
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic enq(input logic [3:0] d);
        step(1, d, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic p0, p1;
        logic [3:0] v0, v1;
        logic [3:0] tmp [4];
        for (int i = 0; i < 8; i++) rf[i] = 4'($urandom_range(15));
        m_reset();
        repeat (2) @(posedge clk);

        do_rst();
        step(0, 0, 0, 0, 0, 0, 0);

        // single enqueue then state check
        enq(4'd3);
        step(0, 0, 0, 0, 0, 0, 0);

        // round-robin tie breaking
        do_rst();
        repeat (4) step(1, 4'd1, 1, 4'd2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        tmp[0] = 4'd1; tmp[1] = 4'd2; tmp[2] = 4'd1; tmp[3] = 4'd2;
        for (int i = 0; i < 4; i++) chk("rf_rr", rf[i], tmp[i]);

        // full queue: dequeue wins, enqueue follows
        do_rst();
        for (int i = 0; i < 8; i++) enq(4'(i + 4));
        step(0, 0, 1, 4'd9, 0, 0, 0);
        step(0, 0, 1, 4'd9, 1, 0, 0);
        step(0, 0, 1, 4'd9, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // simultaneous enqueue and dequeue
        do_rst();
        for (int i = 0; i < 3; i++) enq(4'(i + 7));
        step(1, 4'd5, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // dequeue while empty
        do_rst();
        repeat (3) step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // reset in the middle of a clear sequence
        do_rst();
        for (int i = 0; i < 5; i++) enq(4'(i + 1));
        step(0, 0, 0, 0, 0, 1, 0);
        repeat (3) step(1, 4'd6, 0, 0, 1, 1, 0);
        step(1, 4'd6, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // full clear sequence with a pending request
        for (int i = 0; i < 5; i++) enq(4'(i + 9));
        step(0, 0, 0, 0, 0, 1, 0);
        repeat (8) step(1, 4'd6, 0, 0, 1, 1, 0);
        #1;
        for (int i = 0; i < 8; i++) chk("rf_cleared", rf[i], 0);
        step(1, 4'd6, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // randomized traffic, requests held until acknowledged
        do_rst();
        p0 = 0; p1 = 0; v0 = 0; v1 = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!p0 && $urandom_range(99) < 50) begin
                p0 = 1; v0 = 4'($urandom_range(15));
            end
            if (!p1 && $urandom_range(99) < 50) begin
                p1 = 1; v1 = 4'($urandom_range(15));
            end
            step(p0, v0, p1, v1, $urandom_range(99) < 45,
                 $urandom_range(99) < 3, $urandom_range(199) == 0);
            if (m_g == 0) p0 = 0;
            if (m_g == 1) p1 = 0;
        end
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/queue_arbiter.md
QUEUE_ARBITER -- requirements
Module: queue_arbiter

Interface
REQ-001 Parameters: none; depth is fixed at 8 entries and data width at 4 bits.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req0, req1  in  1 each  enqueue request, level; held with data stable until acknowledged.
REQ-005 din0, din1  in  4 each  enqueue data for requester 0 and 1.
REQ-006 ack0, ack1  out  1 each  grant/accept strobe, combinational, one cycle per accepted item.
REQ-007 deq  in  1  dequeue request, level.
REQ-008 dout  out  4  dequeued data, registered.
REQ-009 dvalid  out  1  one-cycle strobe marking dout updated.
REQ-010 flush  in  1  start clear sequence, sampled in IDLE only.
REQ-011 busy  out  1  high while in FLUSH state.
REQ-012 full, emp  out  1 each  count==8, count==0.
REQ-013 count  out  4  occupancy 0..8.
REQ-014 valid  out  8  per-slot occupancy bitmap for the display unit.
REQ-015 rp, wp  out  3 each  read/write pointers.
REQ-016 ra  out  3  RF read address (combinational read port), always equals rp.
REQ-017 rd  in  4  RF read data.
REQ-018 we, wa, wd  out  1/3/4  RF write port; RF writes on the clk edge when we=1.

Function
REQ-019 States: IDLE and FLUSH; reset enters IDLE.
REQ-020 In IDLE, enqueue grant only if count<8 (current-cycle count); at most one grant per cycle.
REQ-021 If exactly one reqN is high, that requester is granted.
REQ-022 If both are high, grant goes to the requester indicated by prio; after any grant, prio becomes the non-granted requester index (round-robin).
REQ-023 On a grant: ackN=1, we=1, wa=wp, wd=dinN; at the edge, valid[wp]<=1 and wp<=wp+1 (mod 8, wraps 7->0).
REQ-024 With no grant: we=0, ack0=ack1=0; wa and wd are don't-care.
REQ-025 Dequeue is accepted in IDLE when deq=1 and count>0; at the edge, dout<=rd, dvalid<=1, valid[rp]<=0, rp<=rp+1 mod 8.
REQ-026 dvalid is 0 in every cycle not following an accepted dequeue; a held deq dequeues one item per cycle.
REQ-027 Simultaneous grant and dequeue in the same cycle: both occur and count is unchanged.
REQ-028 When full, deq together with req: only the dequeue occurs; the enqueue is granted the next cycle.
REQ-029 When empty, deq together with req: only the enqueue occurs; no bypass; dvalid stays 0.
REQ-030 count: +1 on grant only, -1 on dequeue only, unchanged otherwise; full and emp are derived from count.
REQ-031 flush=1 in IDLE: at the edge, enter FLUSH, set cycle counter k=0 and busy=1; any grant or dequeue in that same cycle still completes.
REQ-032 In FLUSH, for each of 8 cycles: we=1, wa=k, wd=0, k<=k+1; no acks and no dequeues. After k=7, return to IDLE with rp=wp=0, count=0, valid=0, busy=0.
REQ-033 In FLUSH, the flush input is ignored; requests remain pending.
REQ-034 dout holds its last value except on an accepted dequeue.

Reset
REQ-035 rst is synchronous, active-high, and overrides everything, including mid-FLUSH.
REQ-036 Reset values: state=IDLE, rp=wp=0, count=0, valid=0, prio=0, dout=0, dvalid=0, busy=0, full=0, emp=1, ack0=ack1=0, we=0.
REQ-037 RF contents are not cleared by rst; only FLUSH clears them.

Verification
REQ-038 Reset, then req0 with din0=3 for one cycle: ack0=1, wa=0, wd=3; next cycle count=1, valid=8'h01, emp=0.
REQ-039 req0 and req1 held with din0=1, din1=2 for 4 cycles: grants alternate 0,1,0,1; RF slots 0..3 hold 1,2,1,2.
REQ-040 Fill to 8 items (full=1, wp=0 after wrap), keep req1 high and pulse deq: ack1=0 in the deq cycle; dout equals the first item next cycle; ack1=1 the following cycle.
REQ-041 count=3, req0 and deq in the same cycle: ack0=1 and dvalid=1 next cycle; count stays 3.
REQ-042 Empty queue, deq held 3 cycles: dvalid stays 0 and rp, count and valid are unchanged.
REQ-043 count=5, pulse flush, then assert rst on the 4th FLUSH cycle: all outputs take reset values. Repeat without rst: after 8 cycles busy=0, count=0, and the 8 RF slots read 0.
